// File: rtl/dtree_seq_eval.sv
// -----------------------------------------------------------------------------
// dtree_seq_eval
//   Sequential decision-tree evaluator. A register-based node table is loaded
//   through a simple write port while idle. Each accepted feature vector is
//   walked through the table one node per clock until a leaf (class result) or
//   a table fault (bad feature index, or the depth limit hit) ends the walk.
//   The result is held with a valid/ready handshake.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset (clears FSM, result, features
//                and the whole node table)
//   cfg_we     : node-table write strobe (honoured in IDLE only)
//   cfg_addr   : node index to write
//   cfg_wdata  : node word {is_int, feat_idx, thr(signed), t_idx, f_idx}
//   in_valid   : feature vector valid
//   in_ready   : block accepts a feature vector (IDLE and no table write)
//   in_feat    : flattened features, feature i at [i*FEAT_W +: FEAT_W]
//   out_valid  : result valid
//   out_ready  : consumer accepts the result
//   out_class  : predicted class
//   out_err    : inference aborted on a table fault
//   busy       : high while walking or holding a result
// -----------------------------------------------------------------------------
module dtree_seq_eval #(
    parameter int N_FEAT    = 7,
    parameter int FEAT_W    = 8,
    parameter int CMP_W     = 3,
    parameter int N_NODES   = 32,
    parameter int CLASS_W   = 5,
    parameter int MAX_DEPTH = 15,
    localparam int FIDX_W   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1,
    localparam int NODE_W   = (N_NODES > 1) ? $clog2(N_NODES) : 1,
    localparam int WORD_W   = 1 + FIDX_W + CMP_W + 2 * NODE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [NODE_W-1:0]        cfg_addr,
    input  logic [WORD_W-1:0]        cfg_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] in_feat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic                     out_err,
    output logic                     busy
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam logic [FIDX_W:0]    FIDX_LIM  = (FIDX_W + 1)'(N_FEAT);
    localparam logic [DEPTH_W-1:0] DEPTH_LIM = DEPTH_W'(MAX_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [WORD_W-1:0]         table_q [N_NODES];
    logic [N_FEAT*FEAT_W-1:0]  feat_q, feat_d;
    logic [NODE_W-1:0]         ptr_q, ptr_d;
    logic [DEPTH_W-1:0]        depth_q, depth_d;
    logic [CLASS_W-1:0]        class_q, class_d;
    logic                      err_q, err_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;

    // Decoded fields of the node under the pointer
    logic [WORD_W-1:0]         node_s;
    logic                      node_int_s;
    logic [FIDX_W-1:0]         node_fidx_s;
    logic signed [CMP_W-1:0]   node_thr_s;
    logic [NODE_W-1:0]         node_t_s;
    logic [NODE_W-1:0]         node_f_s;
    logic signed [CMP_W-1:0]   sel_msb_s;
    logic                      fault_s;
    logic                      take_t_s;
    logic                      in_ready_s;
    logic                      unused_bits_s;

    assign node_s      = table_q[ptr_q];
    assign node_int_s  = node_s[WORD_W-1];
    assign node_fidx_s = node_s[WORD_W-2 -: FIDX_W];
    assign node_thr_s  = node_s[2*NODE_W + CMP_W - 1 -: CMP_W];
    assign node_t_s    = node_s[2*NODE_W - 1 -: NODE_W];
    assign node_f_s    = node_s[NODE_W-1:0];

    // A table write in the same cycle wins over accepting a new vector
    assign in_ready_s  = (state_q == ST_IDLE) && !cfg_we;
    assign in_ready    = in_ready_s;

    // Only the top CMP_W bits of each feature take part in comparisons
    assign unused_bits_s = ^{feat_q, node_t_s};

    // Pick the compared MSB field of the addressed feature (zero if out of range)
    always_comb begin
        sel_msb_s = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            sel_msb_s = (node_fidx_s == FIDX_W'(i))
                      ? feat_q[i*FEAT_W + FEAT_W - CMP_W +: CMP_W]
                      : sel_msb_s;
        end
    end

    // Fault overrides the branch test; comparison is signed on both sides
    assign fault_s  = ({1'b0, node_fidx_s} >= FIDX_LIM) || (depth_q == DEPTH_LIM);
    assign take_t_s = (sel_msb_s <= node_thr_s);

    // Next-state and result logic for the IDLE/WALK/DONE controller
    always_comb begin
        state_d = state_q;
        feat_d  = feat_q;
        ptr_d   = ptr_q;
        depth_d = depth_q;
        class_d = class_q;
        err_d   = err_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_s) begin
                    feat_d  = in_feat;
                    ptr_d   = '0;
                    depth_d = '0;
                    state_d = ST_WALK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WALK: begin
                if (!node_int_s) begin
                    class_d = node_t_s[CLASS_W-1:0];
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else if (fault_s) begin
                    class_d = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ptr_d   = take_t_s ? node_t_s : node_f_s;
                    depth_d = depth_q + DEPTH_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Controller, walk and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            feat_q  <= '0;
            ptr_q   <= '0;
            depth_q <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            feat_q  <= feat_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            class_q <= class_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Node table: cleared to class-0 leaves on reset, writable only in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_q <= '{default: '0};
        end else if (cfg_we && (state_q == ST_IDLE)) begin
            table_q[cfg_addr] <= cfg_wdata;
        end
    end

    assign out_valid = valid_q;
    assign out_class = class_q;
    assign out_err   = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dtree_seq_eval.sv
module tb_dtree_seq_eval;

    localparam int N_FEAT    = 7;
    localparam int FEAT_W    = 8;
    localparam int CMP_W     = 3;
    localparam int N_NODES   = 32;
    localparam int CLASS_W   = 5;
    localparam int MAX_DEPTH = 15;
    localparam int NODE_W    = 5;
    localparam int WORD_W    = 17;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cfg_we;
    logic [NODE_W-1:0]        cfg_addr;
    logic [WORD_W-1:0]        cfg_wdata;
    logic                     in_valid;
    logic                     in_ready;
    logic [N_FEAT*FEAT_W-1:0] in_feat;
    logic                     out_valid;
    logic                     out_ready;
    logic [CLASS_W-1:0]       out_class;
    logic                     out_err;
    logic                     busy;

    always #5 clk = ~clk;

    dtree_seq_eval #(
        .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CMP_W(CMP_W),
        .N_NODES(N_NODES), .CLASS_W(CLASS_W), .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_err(out_err), .busy(busy)
    );

    // Reference tree kept as plain integers
    int m_int [N_NODES];
    int m_fidx[N_NODES];
    int m_thr [N_NODES];
    int m_t   [N_NODES];
    int m_f   [N_NODES];
    int feat  [N_FEAT];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N_NODES; i++) begin
            m_int[i] = 0; m_fidx[i] = 0; m_thr[i] = 0; m_t[i] = 0; m_f[i] = 0;
        end
    endtask

    // Signed value of the top 3 bits of a byte
    function automatic int msb_val(input int b);
        int v;
        v = (b >> 5) & 7;
        if (v >= 4) v = v - 8;
        return v;
    endfunction

    // Walk the reference tree; steps = internal nodes passed before the end
    task automatic model(output int cls, output int err, output int steps);
        int p, d;
        p = 0; d = 0; cls = 0; err = 0; steps = 0;
        for (int it = 0; it < 100; it++) begin
            if (m_int[p] == 0) begin
                cls = m_t[p] % 32; err = 0; steps = d; return;
            end
            if (m_fidx[p] >= N_FEAT || d == MAX_DEPTH) begin
                cls = 0; err = 1; steps = d; return;
            end
            p = (msb_val(feat[m_fidx[p]]) <= m_thr[p]) ? m_t[p] : m_f[p];
            d++;
        end
    endtask

    function automatic logic [N_FEAT*FEAT_W-1:0] pack_feat();
        logic [N_FEAT*FEAT_W-1:0] v;
        logic [7:0] b;
        v = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            b = 8'(feat[i]);
            v[i*FEAT_W +: FEAT_W] = b;
        end
        return v;
    endfunction

    // Write one node through the config port and mirror it in the model
    task automatic set_node(input int a, input int isint, input int fi,
                            input int th, input int t, input int f);
        logic [31:0] vi, vf, vth, vt, vff;
        m_int[a] = isint; m_fidx[a] = fi; m_thr[a] = th; m_t[a] = t; m_f[a] = f;
        vi = isint; vf = fi; vth = th; vt = t; vff = f;
        cfg_addr  = 5'(a);
        cfg_wdata = {vi[0], vf[2:0], vth[2:0], vt[4:0], vff[4:0]};
        cfg_we    = 1'b1;
        #1;
        chk("ready_low_on_write", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // One inference: handshake, latency, result, optional backpressure, release
    task automatic run_infer(input string tag, input int hold);
        int cls, err, steps, w, cyc;
        logic [CLASS_W-1:0] cls_seen;
        logic err_seen;
        model(cls, err, steps);
        w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_feat  = pack_feat();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        cyc = 0;
        do begin
            in_feat = {$urandom, $urandom};
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid && cyc < 40);
        chk({tag, "_latency"}, 32'(cyc), 32'(steps + 1));
        chk({tag, "_class"}, {27'd0, out_class}, 32'(cls));
        chk({tag, "_err"}, {31'd0, out_err}, 32'(err));
        cls_seen = out_class;
        err_seen = out_err;
        for (int i = 0; i < hold; i++) begin
            cfg_we    = 1'b1;
            cfg_addr  = 5'($urandom_range(0, 31));
            cfg_wdata = 17'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_class"}, {27'd0, out_class}, {27'd0, cls_seen});
            chk({tag, "_hold_err"}, {31'd0, out_err}, {31'd0, err_seen});
            chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
        end
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rel_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
        clear_model();
        for (int i = 0; i < N_FEAT; i++) feat[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_class", {27'd0, out_class}, 32'd0);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Empty table: every vector lands on the class-0 root leaf
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N_FEAT; i++) feat[i] = $urandom_range(0, 255);
            run_infer("empty", 0);
        end

        // Depth-2 tree
        set_node(0, 1, 6, 0, 1, 2);
        set_node(1, 0, 0, 0, 165 % 32, 0);
        set_node(2, 0, 0, 0, 25, 0);
        feat[6] = 8'h10; run_infer("d2_true", 0);
        chk("d2_true_cls_const", {27'd0, out_class}, 32'd5);
        feat[6] = 8'h60; run_infer("d2_false", 0);
        chk("d2_false_cls_const", {27'd0, out_class}, 32'd25);

        // Signed threshold -2
        set_node(0, 1, 6, -2, 1, 2);
        feat[6] = 8'hA0; run_infer("sgn_true", 0);
        feat[6] = 8'hE0; run_infer("sgn_false", 0);
        feat[6] = 8'hC0; run_infer("sgn_equal", 0);

        // Loop fault and bad feature index
        set_node(0, 1, 3, 0, 0, 0);
        run_infer("loop", 0);
        set_node(0, 1, 7, 0, 1, 2);
        run_infer("bad_fidx", 0);

        // Backpressure with ignored writes, then same tree must still answer
        set_node(0, 1, 6, 0, 1, 2);
        feat[6] = 8'h10; run_infer("bp", 10);
        feat[6] = 8'h60; run_infer("bp_after", 0);
        feat[6] = 8'h10; run_infer("bp_after2", 0);

        // Random small trees
        for (int r = 0; r < 30; r++) begin
            for (int a = 0; a < 8; a++) begin
                if ($urandom_range(0, 9) < 6)
                    set_node(a, 1, $urandom_range(0, 7), $urandom_range(0, 7) - 4,
                             $urandom_range(0, 7), $urandom_range(0, 7));
                else
                    set_node(a, 0, 0, 0, $urandom_range(0, 31), 0);
            end
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < N_FEAT; i++) feat[i] = $urandom_range(0, 255);
                run_infer("rand", $urandom_range(0, 2));
            end
        end

        // Reset in the middle of a 5-deep walk
        for (int a = 0; a < 5; a++) set_node(a, 1, 0, 3, a + 1, a + 1);
        set_node(5, 0, 0, 0, 9, 0);
        in_feat  = pack_feat();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_class", {27'd0, out_class}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_infer("post_rst_root", 0);
        // Every other node reached via the root must be a class-0 leaf
        for (int k = 1; k < N_NODES; k++) begin
            set_node(0, 1, 0, 3, k, k);
            run_infer("post_rst_node", 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
